// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
//   ctrl_state_t : controller FSM state (RUN, DRAIN, HALTED)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs and stage-control outputs between the 5-stage datapath and
// pipeline_ctrl.
//   master : datapath side (drives hazard status, receives enables/flushes)
//   slave  : controller side
// With PIPE_PERF_EN defined, stall_cnt/flush_cnt perf counters are carried as well.
interface pipeline_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4
);

  logic                  imem_ready;
  logic                  dmem_req;
  logic                  dmem_ready;
  logic                  id_halt;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_br_taken;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic halted;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    output imem_ready, dmem_req, dmem_ready, id_halt, id_rs1, id_rs2, id_use_rs2,
           ex_mem_read, ex_rd, ex_br_taken,
`ifdef PIPE_PERF_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted
  );

  modport slave (
    input  imem_ready, dmem_req, dmem_ready, id_halt, id_rs1, id_rs2, id_use_rs2,
           ex_mem_read, ex_rd, ex_br_taken,
`ifdef PIPE_PERF_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. x0 (index 0) is never a hazard.
//   ex_mem_read, ex_rd          : load in EX and its destination
//   id_rs1, id_rs2, id_use_rs2  : ID source operands
//   load_use                    : one bubble required
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs2,
  output logic                  load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline. Generates enables and sync-clear
// flushes for PC, IF_ID, ID_EX, EX_MEM, MEM_WB covering dmem freezes, taken-branch flushes,
// load-use bubbles, imem wait states and the HALT drain.
//   clk, reset : clock, asynchronous active-low reset
//   ctrl       : pipeline_ctrl_if.slave (hazard inputs, stage controls, halted)
// Outputs are combinational from state and inputs. Optional macro PIPE_PERF_EN adds the
// 32-bit stall_cnt/flush_cnt perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic             clk,
  input logic             reset,
  pipeline_ctrl_if.slave  ctrl
);

  localparam int unsigned        DrainW    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0]  DrainInit = DrainW'(DRAIN_CYCLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;

  logic load_use;
  logic dfreeze;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, halted;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_mem_read (ctrl.ex_mem_read),
    .ex_rd       (ctrl.ex_rd),
    .id_rs1      (ctrl.id_rs1),
    .id_rs2      (ctrl.id_rs2),
    .id_use_rs2  (ctrl.id_use_rs2),
    .load_use    (load_use)
  );

  assign dfreeze = ctrl.dmem_req && !ctrl.dmem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    if (!reset) begin
      // Hold the front of the pipe cleared while reset is asserted.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (dfreeze) begin
      // Whole pipe frozen; state and drain count hold.
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      unique case (state_q)
        RUN: begin
          if (ctrl.ex_br_taken) begin
            // PC loads the target; wrong-path IF/ID work is squashed, halt is cancelled.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!ctrl.imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end else if (ctrl.id_halt) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = DRAIN;
            drain_d     = DrainInit;
          end
        end
        DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (drain_q == '0) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q - DrainW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl.pc_en       = pc_en;
  assign ctrl.if_id_en    = if_id_en;
  assign ctrl.id_ex_en    = id_ex_en;
  assign ctrl.ex_mem_en   = ex_mem_en;
  assign ctrl.mem_wb_en   = mem_wb_en;
  assign ctrl.if_id_flush = if_id_flush;
  assign ctrl.id_ex_flush = id_ex_flush;
  assign ctrl.halted      = halted;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_evt;
  logic        br_evt;

  // Freeze cycles are not stalls; only RUN-state front-end holds are counted.
  assign stall_evt = (state_q == RUN) && !dfreeze && !pc_en;
  assign br_evt    = (state_q == RUN) && !dfreeze && ctrl.ex_br_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_evt)    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign ctrl.stall_cnt = stall_cnt_q;
  assign ctrl.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Each driven cycle pushes its expected control
// vector {pc,if_id,id_ex,ex_mem,mem_wb en, if_id_flush, id_ex_flush, halted}; a negedge
// monitor pops and compares against the DUT.
module tb_pipeline_ctrl;

  localparam logic [7:0] VRun    = 8'b11111_00_0;
  localparam logic [7:0] VLdUse  = 8'b00111_01_0;
  localparam logic [7:0] VBranch = 8'b11111_11_0;
  localparam logic [7:0] VIWait  = 8'b01111_10_0;
  localparam logic [7:0] VHalt   = 8'b01111_11_0;
  localparam logic [7:0] VDrain  = 8'b01111_11_0;
  localparam logic [7:0] VFreeze = 8'b00000_00_0;
  localparam logic [7:0] VHalted = 8'b00000_00_1;
  localparam logic [7:0] VReset  = 8'b00000_11_0;

  logic clk;
  logic reset;

  pipeline_ctrl_if #(.REG_ADDR_W(4)) bus ();

  pipeline_ctrl #(
    .REG_ADDR_W   (4),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.imem_ready  = 1'b1;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b1;
    bus.id_halt     = 1'b0;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_br_taken = 1'b0;
  endtask

  // Inputs are already applied; record expectation and advance one cycle.
  task automatic expect_cycle(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(),
            {24'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
             bus.if_id_flush, bus.id_ex_flush, bus.halted},
            {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;

    // T1: reset held, then first RUN cycle
    for (int i = 0; i < 3; i++) expect_cycle("reset", VReset);
    reset = 1'b1;
    expect_cycle("run_first", VRun);

    // T2: load-use on rs1, ex_rd=0, rs2 with and without use
    bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd5; bus.id_rs1 = 4'd5;
    expect_cycle("lduse_rs1", VLdUse);
    idle_inputs();
    expect_cycle("lduse_after", VRun);
    bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd0; bus.id_rs1 = 4'd0;
    expect_cycle("lduse_x0", VRun);
    bus.ex_rd = 4'd7; bus.id_rs1 = 4'd3; bus.id_rs2 = 4'd7; bus.id_use_rs2 = 1'b1;
    expect_cycle("lduse_rs2", VLdUse);
    bus.id_use_rs2 = 1'b0;
    expect_cycle("lduse_rs2_unused", VRun);
    idle_inputs();
    bus.imem_ready = 1'b0;
    expect_cycle("iwait", VIWait);
    idle_inputs();

    // T3: branch beats halt and load-use
    bus.ex_br_taken = 1'b1; bus.id_halt = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd2; bus.id_rs1 = 4'd2;
    expect_cycle("branch_prio", VBranch);
    idle_inputs();
    expect_cycle("branch_stays_run", VRun);

    // T4: dmem freeze for 4 cycles, branch pending is held off too
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle("dfreeze", VFreeze);
    bus.ex_br_taken = 1'b1;
    expect_cycle("dfreeze_br", VFreeze);
    bus.ex_br_taken = 1'b0; bus.dmem_ready = 1'b1;
    expect_cycle("dfreeze_release", VRun);
    idle_inputs();
`ifdef PIPE_PERF_EN
    check("stall_cnt_t4", bus.stall_cnt, 32'd3);
    check("flush_cnt_t4", bus.flush_cnt, 32'd1);
`endif

    // T5: halt, drain with one freeze, halted ignores inputs
    bus.id_halt = 1'b1;
    expect_cycle("halt_run", VHalt);
    bus.id_halt = 1'b0;
    expect_cycle("drain_1", VDrain);
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    expect_cycle("drain_freeze", VFreeze);
    idle_inputs();
    bus.ex_br_taken = 1'b1; bus.imem_ready = 1'b0; bus.id_halt = 1'b1;
    expect_cycle("drain_2_ignore", VDrain);
    idle_inputs();
    expect_cycle("drain_3", VDrain);
    expect_cycle("halted", VHalted);
    bus.ex_br_taken = 1'b1;
    expect_cycle("halted_br", VHalted);
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    expect_cycle("halted_freeze", VHalted);
    idle_inputs();
    reset = 1'b0;
    expect_cycle("halted_reset", VReset);
    reset = 1'b1;
    expect_cycle("run_after_reset", VRun);

    // Reset mid-drain returns straight to RUN
    bus.id_halt = 1'b1;
    expect_cycle("halt_run2", VHalt);
    bus.id_halt = 1'b0;
    expect_cycle("drain_again", VDrain);
    reset = 1'b0;
    expect_cycle("drain_reset", VReset);
    reset = 1'b1;
    expect_cycle("run_after_drain_reset", VRun);

`ifdef PIPE_PERF_EN
    // T6: counters from a fresh reset
    check("stall_cnt_clr", bus.stall_cnt, 32'd0);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 10; i++) expect_cycle("perf_iwait", VIWait);
    idle_inputs();
    check("stall_cnt_10", bus.stall_cnt, 32'd10);
    force dut.flush_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.flush_cnt_q;
    bus.ex_br_taken = 1'b1;
    expect_cycle("perf_branch", VBranch);
    idle_inputs();
    check("flush_cnt_wrap", bus.flush_cnt, 32'd0);
    check("stall_cnt_hold", bus.stall_cnt, 32'd10);
`endif

    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
